// File: rtl/seg_pkg.sv
// Shared constants, shadow-register layout and the BCD to active-low
// segment table for the multiplexed 7-segment scan driver.
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [5:0] AN_OFF    = 6'h3F;
   localparam int         IDX_W     = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);

   // One frame's worth of latched inputs; digs[4*i +: 4] is digit i.
   typedef struct packed {
      logic [23:0] digs;
      logic [5:0]  dp;
      logic [5:0]  blink;
      logic        lz;
   } shadow_t;

   localparam shadow_t SHADOW_RST = '{digs: {6{4'hF}}, dp: 6'h00, blink: 6'h00, lz: 1'b0};

   // Segment order {g,f,e,d,c,b,a}, active-low; non-BCD codes stay dark.
   function automatic logic [6:0] bcd_seg(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h18;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 are blank.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   assign seg_n = bcd_seg(bcd);

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit time-multiplexed common-anode display driver with frame-stable
// shadow digits, leading-zero blanking, per-digit blink and an anti-ghost guard.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIV          = 250,
   parameter int GUARD        = 2,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk50,
   input  logic       key,
   input  logic [3:0] dig5,
   input  logic [3:0] dig4,
   input  logic [3:0] dig3,
   input  logic [3:0] dig2,
   input  logic [3:0] dig1,
   input  logic [3:0] dig0,
   input  logic [5:0] dp_mask,
   input  logic [5:0] blink_mask,
   input  logic       lz_en,
   output logic [5:0] an_n,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic       frame_tick
);

   localparam int PRE_W = $clog2(DIV);
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic             blink_ph_q, blink_ph_d;
   logic             valid_q, valid_d;
   shadow_t          shadow_q, shadow_d;
   logic [5:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             tick_q, tick_d;

   logic             slot_end;
   logic             wrap;
   logic [3:0]       cur_digit;
   logic [6:0]       seg_raw;
   logic             blank;

   always_comb begin
      slot_end    = (pre_q == PRE_W'(DIV - 1));
      wrap        = slot_end && (idx_q == LAST_IDX);
      pre_d       = slot_end ? '0 : pre_q + 1'b1;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      frame_cnt_d = frame_cnt_q;
      blink_ph_d  = blink_ph_q;
      valid_d     = valid_q;
      tick_d      = wrap;
      if (slot_end) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
      end
      // The whole input set is captured once per frame so a digit never tears.
      if (wrap) begin
         shadow_d.digs  = {dig5, dig4, dig3, dig2, dig1, dig0};
         shadow_d.dp    = dp_mask;
         shadow_d.blink = blink_mask;
         shadow_d.lz    = lz_en;
         valid_d        = 1'b1;
         if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   assign cur_digit = shadow_q.digs[{idx_q, 2'b00} +: 4];

   bcd_to_seg u_bcd_to_seg (
      .bcd   (cur_digit),
      .seg_n (seg_raw)
   );

   always_comb begin
      blank = (shadow_q.blink[idx_q] && blink_ph_q)
           || ((idx_q == LAST_IDX) && shadow_q.lz && (cur_digit == 4'd0))
           || (cur_digit > 4'd9);
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      // Before the first shadow load there is nothing valid to show.
      if (valid_q && (pre_q >= PRE_W'(GUARD))) begin
         an_d = ~(6'b000001 << idx_q);
         if (!blank) begin
            seg_d = seg_raw;
            dp_d  = ~shadow_q.dp[idx_q];
         end
      end
   end

   always_ff @(posedge clk50 or negedge key) begin
      if (!key) begin
         pre_q       <= '0;
         idx_q       <= LAST_IDX;
         frame_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         valid_q     <= 1'b0;
         shadow_q    <= SHADOW_RST;
         an_q        <= AN_OFF;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
         tick_q      <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         blink_ph_q  <= blink_ph_d;
         valid_q     <= valid_d;
         shadow_q    <= shadow_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         tick_q      <= tick_d;
      end
   end

   assign an_n       = an_q;
   assign seg_n      = seg_q;
   assign dp_n       = dp_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: outputs are predicted from the cycle count since
// reset and the input set present on each frame-load cycle.
module tb_seg_scan_driver;

   localparam int DIV   = 4;
   localparam int GUARD = 1;
   localparam int BF    = 2;
   localparam int FRAME = 6 * DIV;

   logic       clk50 = 1'b0;
   logic       key   = 1'b0;
   logic [3:0] dig [6];
   logic [5:0] dp_mask    = 6'h00;
   logic [5:0] blink_mask = 6'h00;
   logic       lz_en      = 1'b0;
   logic [5:0] an_n;
   logic [6:0] seg_n;
   logic       dp_n;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [6:0]  seg_ref [10];
   logic [3:0]  s_dig [256][6];
   logic [5:0]  s_dp  [256];
   logic [5:0]  s_bm  [256];
   logic        s_lz  [256];
   logic [14:0] exp_v;

   seg_scan_driver #(.DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
      .clk50      (clk50),
      .key        (key),
      .dig5       (dig[5]),
      .dig4       (dig[4]),
      .dig3       (dig[3]),
      .dig2       (dig[2]),
      .dig1       (dig[1]),
      .dig0       (dig[0]),
      .dp_mask    (dp_mask),
      .blink_mask (blink_mask),
      .lz_en      (lz_en),
      .an_n       (an_n),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .frame_tick (frame_tick)
   );

   always #5 clk50 = ~clk50;

   // Inputs as they stand during a frame-load cycle become that frame's digits.
   always @(negedge clk50) begin
      if (key && cyc >= DIV - 1 && (cyc - (DIV - 1)) % FRAME == 0) begin
         for (int i = 0; i < 6; i++) s_dig[(cyc - (DIV - 1)) / FRAME + 1][i] <= dig[i];
         s_dp[(cyc - (DIV - 1)) / FRAME + 1] <= dp_mask;
         s_bm[(cyc - (DIV - 1)) / FRAME + 1] <= blink_mask;
         s_lz[(cyc - (DIV - 1)) / FRAME + 1] <= lz_en;
      end
   end

   function automatic int load_cyc(input int f);
      return DIV - 1 + (f - 1) * FRAME;
   endfunction

   function automatic int load_frame(input int c);
      if (c <= DIV - 1) return 1;
      return (c - (DIV - 1) + FRAME - 1) / FRAME + 1;
   endfunction

   function automatic int lit_cyc(input int f, input int slot);
      return load_cyc(f) + slot * DIV + GUARD + 2;
   endfunction

   // Expected {an_n, seg_n, dp_n, frame_tick} while in cycle n after reset release.
   function automatic logic [14:0] model(input int n);
      int c, pre, s, f, idx;
      logic [3:0] d;
      logic ph, blank;
      logic [5:0] an;
      logic [6:0] seg;
      logic dp, tk;
      an = 6'h3F; seg = 7'h7F; dp = 1'b1; tk = 1'b0;
      c = n - 1;
      if (c >= DIV - 1 && (c - (DIV - 1)) % FRAME == 0) tk = 1'b1;
      if (c >= 0) begin
         pre = c % DIV;
         s   = c / DIV;
         if (s >= 1 && pre >= GUARD) begin
            f     = (s - 1) / 6 + 1;
            idx   = (s - 1) % 6;
            d     = s_dig[f][idx];
            ph    = ((f / BF) % 2) == 1;
            blank = (s_bm[f][idx] && ph) || (idx == 5 && s_lz[f] && d == 4'd0) || (d > 4'd9);
            an    = ~(6'd1 << idx);
            if (!blank) begin
               seg = seg_ref[d];
               dp  = ~s_dp[f][idx];
            end
         end
      end
      return {an, seg, dp, tk};
   endfunction

   task automatic step();
      @(posedge clk50);
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) dig[i] = 4'(6 - i);
      key = 1'b0;
      #12;
      checks++;
      if ({an_n, seg_n, dp_n, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_hold got=%h exp=%h", {an_n, seg_n, dp_n, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
      end
      @(negedge clk50);
      key = 1'b1;
      cyc = 0;
      #1;
      checks++;
      if ({an_n, seg_n, dp_n, frame_tick} !== model(0)) begin
         errors++;
         $display("FAIL reset_release got=%h exp=%h", {an_n, seg_n, dp_n, frame_tick}, model(0));
      end
   endtask

   task automatic test_first_frame();
      while (cyc < 2 * FRAME + 4) begin
         step();
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL ff_model cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
         if (cyc <= DIV) begin
            checks++;
            if (an_n !== 6'h3F) begin
               errors++;
               $display("FAIL ff_dark cyc=%0d an_n=%h exp=3f", cyc, an_n);
            end
         end
         if (cyc == DIV) begin
            checks++;
            if (frame_tick !== 1'b1) begin
               errors++;
               $display("FAIL ff_tick cyc=%0d frame_tick=%b exp=1", cyc, frame_tick);
            end
         end
         if (cyc == lit_cyc(1, 0)) begin
            checks++;
            if ({an_n, seg_n} !== {6'h3E, 7'h02}) begin
               errors++;
               $display("FAIL ff_slot0 an_n=%h seg_n=%h exp=3e/02", an_n, seg_n);
            end
         end
         if (cyc == lit_cyc(1, 5)) begin
            checks++;
            if ({an_n, seg_n} !== {6'h1F, 7'h79}) begin
               errors++;
               $display("FAIL ff_slot5 an_n=%h seg_n=%h exp=1f/79", an_n, seg_n);
            end
         end
      end
   endtask

   task automatic test_midframe_change();
      int fa, t_chg;
      dig[0] = 4'd5;
      fa    = load_frame(cyc);
      t_chg = load_cyc(fa) + 2;
      while (cyc < lit_cyc(fa + 1, 0) + 1) begin
         step();
         if (cyc == t_chg) dig[0] = 4'd7;
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL mid_model cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
         if (cyc >= lit_cyc(fa, 0) && cyc < lit_cyc(fa, 0) + DIV - GUARD) begin
            checks++;
            if (seg_n !== 7'h12) begin
               errors++;
               $display("FAIL mid_old cyc=%0d seg_n=%h exp=12", cyc, seg_n);
            end
         end
         if (cyc == lit_cyc(fa + 1, 0)) begin
            checks++;
            if (seg_n !== 7'h78) begin
               errors++;
               $display("FAIL mid_new cyc=%0d seg_n=%h exp=78", cyc, seg_n);
            end
         end
      end
   endtask

   task automatic test_lz();
      int fa, fb;
      lz_en  = 1'b1;
      dig[5] = 4'd0;
      fa = load_frame(cyc);
      while (cyc < lit_cyc(fa, 5)) begin
         step();
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL lz_model cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
      end
      checks++;
      if ({an_n, seg_n, dp_n} !== {6'h1F, 7'h7F, 1'b1}) begin
         errors++;
         $display("FAIL lz_zero an_n=%h seg_n=%h dp_n=%b exp=1f/7f/1", an_n, seg_n, dp_n);
      end
      dig[5] = 4'd2;
      fb = load_frame(cyc);
      while (cyc < lit_cyc(fb, 5)) begin
         step();
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL lz_model cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
      end
      checks++;
      if ({an_n, seg_n} !== {6'h1F, 7'h24}) begin
         errors++;
         $display("FAIL lz_two an_n=%h seg_n=%h exp=1f/24", an_n, seg_n);
      end
   endtask

   task automatic test_blink();
      int fa;
      logic on;
      lz_en      = 1'b0;
      dig[0]     = 4'd6;
      dig[1]     = 4'd5;
      blink_mask = 6'b000011;
      dp_mask    = 6'b000001;
      fa = load_frame(cyc);
      while (cyc < lit_cyc(fa + 3, 1)) begin
         step();
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL blink_model cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
         for (int k = 0; k < 4; k++) begin
            on = (((fa + k) / BF) % 2) == 0;
            if (cyc == lit_cyc(fa + k, 0)) begin
               checks++;
               if ({seg_n, dp_n} !== (on ? {7'h02, 1'b0} : {7'h7F, 1'b1})) begin
                  errors++;
                  $display("FAIL blink_slot0 frame=%0d seg_n=%h dp_n=%b on=%b", fa + k, seg_n, dp_n, on);
               end
            end
            if (cyc == lit_cyc(fa + k, 1)) begin
               checks++;
               if ({seg_n, dp_n} !== (on ? {7'h12, 1'b1} : {7'h7F, 1'b1})) begin
                  errors++;
                  $display("FAIL blink_slot1 frame=%0d seg_n=%h dp_n=%b on=%b", fa + k, seg_n, dp_n, on);
               end
            end
         end
      end
   endtask

   task automatic test_bad_digit();
      int fa;
      blink_mask = 6'h00;
      dig[3]     = 4'hC;
      fa = load_frame(cyc);
      while (cyc < lit_cyc(fa, 3)) begin
         step();
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL bad_model cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
      end
      checks++;
      if ({an_n, seg_n, dp_n} !== {6'h37, 7'h7F, 1'b1}) begin
         errors++;
         $display("FAIL bad_digit an_n=%h seg_n=%h dp_n=%b exp=37/7f/1", an_n, seg_n, dp_n);
      end
   endtask

   task automatic test_random();
      int stop;
      stop = cyc + 8 * FRAME;
      while (cyc < stop) begin
         step();
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 6; i++) dig[i] = 4'($urandom_range(0, 11));
            dp_mask    = 6'($urandom_range(0, 63));
            blink_mask = 6'($urandom_range(0, 63));
            lz_en      = 1'($urandom_range(0, 1));
         end
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int fa;
      for (int i = 0; i < 6; i++) dig[i] = 4'(6 - i);
      fa = load_frame(cyc);
      while (cyc < lit_cyc(fa, 2)) begin
         step();
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL rst_pre cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
      end
      #2;
      key = 1'b0;
      #1;
      checks++;
      if ({an_n, seg_n, dp_n, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rst_async got=%h exp=%h", {an_n, seg_n, dp_n, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
      end
      @(posedge clk50);
      #1;
      checks++;
      if ({an_n, seg_n, dp_n, frame_tick} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rst_held got=%h exp=%h", {an_n, seg_n, dp_n, frame_tick}, {6'h3F, 7'h7F, 1'b1, 1'b0});
      end
      @(negedge clk50);
      key = 1'b1;
      cyc = 0;
      while (cyc < lit_cyc(1, 0) + 1) begin
         step();
         exp_v = model(cyc);
         checks++;
         if ({an_n, seg_n, dp_n, frame_tick} !== exp_v) begin
            errors++;
            $display("FAIL rst_post cyc=%0d got=%h exp=%h", cyc, {an_n, seg_n, dp_n, frame_tick}, exp_v);
         end
         if (cyc <= DIV) begin
            checks++;
            if (an_n !== 6'h3F) begin
               errors++;
               $display("FAIL rst_dark cyc=%0d an_n=%h exp=3f", cyc, an_n);
            end
         end
      end
   endtask

   initial begin
      seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
      test_reset();
      test_first_frame();
      test_midframe_change();
      test_lz();
      test_blink();
      test_bad_digit();
      test_random();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
